// File: rtl/ok_cmd_pkg.sv
// ============================================================================
// ok_cmd_pkg : shared types and constants for the OK command scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package ok_cmd_pkg;

    localparam logic [15:0] HEADER_TRIG = 16'hC7E5;
    localparam logic [15:0] HEADER_UPD  = 16'hB79E;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_TRIG  = 2'd1,
        P_UHDR  = 2'd2,
        P_UDATA = 2'd3
    } parser_state_t;

    typedef struct packed {
        logic [7:0] ep;
        logic [3:0] idx;
    } trig_entry_t;

    function automatic logic [15:0] idx_to_onehot(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ok_cmd_fifo.sv
// ============================================================================
// ok_cmd_fifo : synchronous trigger queue with head and head+1 peek ports
// Rev 1.0
// ============================================================================
`default_nettype none

module ok_cmd_fifo
    import ok_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     push,
    input  trig_entry_t              push_data,
    input  logic                     pop,
    output trig_entry_t              head,
    output trig_entry_t              head_next,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    trig_entry_t          mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count_next;

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + AW'(1)];

    always_comb begin
        count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/ok_cmd_scheduler.sv
// ============================================================================
// ok_cmd_scheduler : host word parser, trigger queue/dispatch, config writes
// Optional idle timeout inside update frames: define CMD_TIMEOUT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module ok_cmd_scheduler
    import ok_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [15:0] ok_data,
    input  logic        data_valid,
    output logic        trig_valid,
    input  logic        trig_ready,
    output logic [7:0]  trig_ep_addr,
    output logic [15:0] trig_onehot,
    output logic        cfg_we,
    output logic [7:0]  cfg_addr,
    output logic [15:0] cfg_wdata,
    output logic        fifo_full,
    output logic        frame_err,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    parser_state_t  state;
    logic [15:0]    w;
    logic [7:0]     addr_ptr;
    logic [7:0]     remaining;
    logic           push;
    logic           pop;
    logic           timeout_hit;
    trig_entry_t    push_data;
    trig_entry_t    head;
    trig_entry_t    head_next;
    logic [CW-1:0]  fifo_count;

    assign w         = {ok_data[7:0], ok_data[15:8]};
    assign push_data = '{ep: w[15:8], idx: w[3:0]};
    // fifo_full reflects the pre-pop count, so a full queue drops even if a pop is pending
    assign push      = data_valid && (state == P_TRIG) && (w[7:4] == 4'd0) && !fifo_full;
    assign pop       = trig_valid && trig_ready;
    assign busy      = (state != P_IDLE) || (fifo_count != '0);

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
    logic          in_update;

    assign in_update   = (state == P_UHDR) || (state == P_UDATA);
    assign timeout_hit = in_update && !data_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in) begin
        if (rst || data_valid || !in_update || timeout_hit) idle_cnt <= '0;
        else                                                idle_cnt <= idle_cnt + TW'(1);
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= P_IDLE;
            addr_ptr  <= '0;
            remaining <= '0;
            cfg_we    <= 1'b0;
            cfg_addr  <= '0;
            cfg_wdata <= '0;
            frame_err <= 1'b0;
        end else begin
            cfg_we    <= 1'b0;
            frame_err <= 1'b0;
            if (timeout_hit) begin
                state     <= P_IDLE;
                frame_err <= 1'b1;
            end else if (data_valid) begin
                case (state)
                    P_IDLE: begin
                        if (w == HEADER_TRIG)     state <= P_TRIG;
                        else if (w == HEADER_UPD) state <= P_UHDR;
                    end
                    P_TRIG: begin
                        if (!push) frame_err <= 1'b1;
                        state <= P_IDLE;
                    end
                    P_UHDR: begin
                        cfg_addr  <= w[15:8];
                        addr_ptr  <= w[15:8];
                        remaining <= w[7:0];
                        state     <= (w[7:0] == 8'd0) ? P_IDLE : P_UDATA;
                    end
                    P_UDATA: begin
                        // cfg_addr carries the address of the write being strobed
                        cfg_we    <= 1'b1;
                        cfg_wdata <= w;
                        cfg_addr  <= addr_ptr;
                        addr_ptr  <= addr_ptr + 8'd1;
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) state <= P_IDLE;
                    end
                    default: state <= P_IDLE;
                endcase
            end
        end
    end

    ok_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in    (clk_in),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .head_next (head_next),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    // The head stays in the queue until transferred; on a pop, head+1 is staged
    always_ff @(posedge clk_in) begin
        if (rst) begin
            trig_valid   <= 1'b0;
            trig_ep_addr <= '0;
            trig_onehot  <= '0;
        end else if (pop) begin
            trig_valid <= (fifo_count > CW'(1));
            if (fifo_count > CW'(1)) begin
                trig_ep_addr <= head_next.ep;
                trig_onehot  <= idx_to_onehot(head_next.idx);
            end
        end else begin
            trig_valid <= (fifo_count != '0);
            if (fifo_count != '0) begin
                trig_ep_addr <= head.ep;
                trig_onehot  <= idx_to_onehot(head.idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ok_cmd_scheduler.sv
// ============================================================================
// tb_ok_cmd_scheduler : directed bench for ok_cmd_scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ok_cmd_scheduler;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ok_data = '0;
    logic        data_valid = 1'b0;
    logic        trig_ready = 1'b0;
    logic        trig_valid;
    logic [7:0]  trig_ep_addr;
    logic [15:0] trig_onehot;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        fifo_full;
    logic        frame_err;
    logic        busy;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int err_cnt = 0;
    logic [7:0]  x_ep[$];
    logic [15:0] x_oh[$];
    int          x_cyc[$];
    logic [7:0]  c_addr[$];
    logic [15:0] c_data[$];

    ok_cmd_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .ok_data      (ok_data),
        .data_valid   (data_valid),
        .trig_valid   (trig_valid),
        .trig_ready   (trig_ready),
        .trig_ep_addr (trig_ep_addr),
        .trig_onehot  (trig_onehot),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .fifo_full    (fifo_full),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (!rst) begin
            if (trig_valid && trig_ready) begin
                x_ep.push_back(trig_ep_addr);
                x_oh.push_back(trig_onehot);
                x_cyc.push_back(cyc);
            end
            if (cfg_we) begin
                c_addr.push_back(cfg_addr);
                c_data.push_back(cfg_wdata);
            end
            if (frame_err) err_cnt <= err_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Drives the logical word w; the wire carries it byte-swapped
    task automatic send(input logic [15:0] word);
        ok_data    = {word[7:0], word[15:8]};
        data_valid = 1'b1;
        step(1);
        data_valid = 1'b0;
    endtask

    task automatic trig_frame(input logic [7:0] ep, input logic [7:0] idx);
        send(16'hC7E5);
        send({ep, idx});
    endtask

    task automatic check_xfer(input string tag, input int k, input logic [7:0] ep, input logic [15:0] oh);
        if (x_ep.size() > k) begin
            check({tag, "_ep"}, 32'(x_ep[k]), 32'(ep));
            check({tag, "_oh"}, 32'(x_oh[k]), 32'(oh));
        end else begin
            check({tag, "_missing"}, 32'(x_ep.size()), 32'(k + 1));
        end
    endtask

    task automatic check_cfg(input string tag, input int k, input logic [7:0] a, input logic [15:0] d);
        if (c_addr.size() > k) begin
            check({tag, "_addr"}, 32'(c_addr[k]), 32'(a));
            check({tag, "_data"}, 32'(c_data[k]), 32'(d));
        end else begin
            check({tag, "_missing"}, 32'(c_addr.size()), 32'(k + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int xb, cb, eb;
        step(3);
        check("rst_trig_valid", 32'(trig_valid), 0);
        check("rst_cfg_we", 32'(cfg_we), 0);
        check("rst_cfg_addr", 32'(cfg_addr), 0);
        check("rst_fifo_full", 32'(fifo_full), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        rst = 1'b0;
        step(1);

        // 1: single trigger, latency
        trig_ready = 1'b1;
        xb = x_ep.size();
        send(16'hC7E5);
        send(16'h0503);
        check("t1_lat1_valid", 32'(trig_valid), 0);
        check("t1_busy", 32'(busy), 1);
        step(1);
        check("t1_lat2_valid", 32'(trig_valid), 1);
        check("t1_ep", 32'(trig_ep_addr), 32'h05);
        check("t1_oh", 32'(trig_onehot), 32'h0008);
        step(3);
        check("t1_count", 32'(x_ep.size() - xb), 1);
        check_xfer("t1_x", xb, 8'h05, 16'h0008);

        // 2: update frame with address wrap
        cb = c_addr.size();
        send(16'hB79E);
        send(16'hFE03);
        send(16'h1234);
        send(16'h5678);
        send(16'h9ABC);
        step(1);
        check("t2_busy", 32'(busy), 0);
        check("t2_count", 32'(c_addr.size() - cb), 3);
        check_cfg("t2_w0", cb,     8'hFE, 16'h1234);
        check_cfg("t2_w1", cb + 1, 8'hFF, 16'h5678);
        check_cfg("t2_w2", cb + 2, 8'h00, 16'h9ABC);

        // 3: fill queue with ready low, fifth frame dropped
        trig_ready = 1'b0;
        xb = x_ep.size();
        eb = err_cnt;
        for (int i = 0; i < 5; i++) trig_frame(8'h10 + 8'(i), 8'(i));
        step(2);
        check("t3_full", 32'(fifo_full), 1);
        check("t3_err", 32'(err_cnt - eb), 1);
        check("t3_head_valid", 32'(trig_valid), 1);
        check("t3_head_ep", 32'(trig_ep_addr), 32'h10);
        check("t3_no_xfer", 32'(x_ep.size() - xb), 0);
        trig_ready = 1'b1;
        step(8);
        check("t3_count", 32'(x_ep.size() - xb), 4);
        for (int i = 0; i < 4; i++)
            check_xfer($sformatf("t3_x%0d", i), xb + i, 8'h10 + 8'(i), 16'd1 << i);
        for (int i = 1; i < 4; i++)
            if (x_cyc.size() > xb + i)
                check($sformatf("t3_b2b%0d", i), 32'(x_cyc[xb + i] - x_cyc[xb + i - 1]), 1);
        check("t3_full_clear", 32'(fifo_full), 0);
        check("t3_idle", 32'(busy), 0);

        // 4: idx out of range
        xb = x_ep.size();
        eb = err_cnt;
        trig_frame(8'h22, 8'h10);
        step(4);
        check("t4_err", 32'(err_cnt - eb), 1);
        check("t4_no_xfer", 32'(x_ep.size() - xb), 0);
        trig_frame(8'h22, 8'h07);
        step(4);
        check_xfer("t4_x", xb, 8'h22, 16'h0080);

        // 5: gaps inside frames
        xb = x_ep.size();
        cb = c_addr.size();
        send(16'hC7E5);
        step(3);
        send(16'h330F);
        step(4);
        check("t5_tcount", 32'(x_ep.size() - xb), 1);
        check_xfer("t5_x", xb, 8'h33, 16'h8000);
        send(16'hB79E);
        step(1);
        send(16'h4002);
        step(2);
        send(16'hAAAA);
        step(1);
        send(16'h5555);
        step(1);
        check("t5_ccount", 32'(c_addr.size() - cb), 2);
        check_cfg("t5_w0", cb,     8'h40, 16'hAAAA);
        check_cfg("t5_w1", cb + 1, 8'h41, 16'h5555);

        // 5b: reset mid update frame with a queued trigger
        trig_ready = 1'b0;
        trig_frame(8'h44, 8'h01);
        send(16'hB79E);
        send(16'h5003);
        send(16'h0101);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check("t5r_cfg_we", 32'(cfg_we), 0);
        check("t5r_cfg_addr", 32'(cfg_addr), 0);
        check("t5r_trig_valid", 32'(trig_valid), 0);
        check("t5r_busy", 32'(busy), 0);
        check("t5r_full", 32'(fifo_full), 0);
        trig_ready = 1'b1;
        xb = x_ep.size();
        cb = c_addr.size();
        send(16'h0202);
        trig_frame(8'h55, 8'h02);
        step(4);
        check("t5r_ccount", 32'(c_addr.size() - cb), 0);
        check("t5r_tcount", 32'(x_ep.size() - xb), 1);
        check_xfer("t5r_x", xb, 8'h55, 16'h0004);

`ifdef CMD_TIMEOUT_EN
        // 6: update frame stalls after two of four words
        cb = c_addr.size();
        eb = err_cnt;
        send(16'hB79E);
        send(16'h6004);
        send(16'h1111);
        send(16'h2222);
        step(7);
        check("t6_no_err_yet", 32'(frame_err), 0);
        check("t6_busy", 32'(busy), 1);
        step(1);
        check("t6_err_pulse", 32'(frame_err), 1);
        check("t6_idle", 32'(busy), 0);
        step(2);
        check("t6_err_count", 32'(err_cnt - eb), 1);
        check("t6_writes", 32'(c_addr.size() - cb), 2);
        check_cfg("t6_w0", cb,     8'h60, 16'h1111);
        check_cfg("t6_w1", cb + 1, 8'h61, 16'h2222);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
